// File: rtl/reg_op_if.sv
// reg_op_if: bundles the command handshake and the register-bank port of
// reg_op_sequencer.
//   Command side : start, op, rs, rt, rd (to sequencer); busy, done (from sequencer)
//   Bank side    : rd_a, rd_b, wr_c, wr_data, wr_en (from sequencer);
//                  rd_data1, rd_data2 (to sequencer, registered in the bank)
//   Status       : result, zero, carry (from sequencer)
// modport master : the sequencer (drives bank addresses/write port and status)
// modport slave  : the decode/test driver together with the register bank
interface reg_op_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
);
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] rd_b;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [ADDR_W-1:0] wr_c;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;

    modport master (
        input  start, op, rs, rt, rd, rd_data1, rd_data2,
        output busy, done, rd_a, rd_b, wr_c, wr_data, wr_en, result, zero, carry
    );

    modport slave (
        output start, op, rs, rt, rd, rd_data1, rd_data2,
        input  busy, done, rd_a, rd_b, wr_c, wr_data, wr_en, result, zero, carry
    );
endinterface

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: runs one three-address register operation rd <- rs OP rt
// against an 8x32 two-read/one-write register bank.
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : reg_op_if.master
//            start/op/rs/rt/rd in, busy/done out (command handshake)
//            rd_a/rd_b out, rd_data1/rd_data2 in (bank reads, 1-cycle latency)
//            wr_c/wr_data/wr_en out (bank write, committed on falling edge)
//            result/zero/carry out (status of the last computed operation)
// Sequence: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE, one cycle each.
// All outputs are registers.
module reg_op_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 3,
    parameter bit          R0_PROTECT = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    reg_op_if.master bus
);

    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    state_e            state_q,   state_d;
    logic [OP_W-1:0]   op_q,      op_d;
    logic [ADDR_W-1:0] rd_q,      rd_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [ADDR_W-1:0] rd_a_q,    rd_a_d;
    logic [ADDR_W-1:0] rd_b_q,    rd_b_d;
    logic [ADDR_W-1:0] wr_c_q,    wr_c_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q,   wr_en_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              zero_q,    zero_d;
    logic              carry_q,   carry_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   sum_ext;
    logic [SHAMT_W-1:0] shamt;

    // ALU on the bank outputs, which are valid during EXEC
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum_ext   = {1'b0, bus.rd_data1} + {1'b0, bus.rd_data2};
        shamt     = bus.rd_data2[SHAMT_W-1:0];
        case (op_e'(op_q))
            OP_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_res   = bus.rd_data1 - bus.rd_data2;
                // borrow out of an unsigned subtract
                alu_carry = (bus.rd_data1 < bus.rd_data2);
            end
            OP_AND: alu_res = bus.rd_data1 & bus.rd_data2;
            OP_OR:  alu_res = bus.rd_data1 | bus.rd_data2;
            OP_XOR: alu_res = bus.rd_data1 ^ bus.rd_data2;
            OP_SLL: alu_res = bus.rd_data1 << shamt;
            OP_SRL: alu_res = bus.rd_data1 >> shamt;
            OP_SLT: alu_res = ($signed(bus.rd_data1) < $signed(bus.rd_data2)) ?
                              DATA_W'(1) : '0;
            default: alu_res = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        wr_c_d    = wr_c_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    op_d    = bus.op;
                    rd_d    = bus.rd;
                    busy_d  = 1'b1;
                    // rd_a/rd_b also serve as the latched source indices
                    rd_a_d  = bus.rs;
                    rd_b_d  = bus.rt;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d   = ST_WRITE;
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                carry_d   = alu_carry;
                wr_c_d    = rd_q;
                wr_data_d = alu_res;
                wr_en_d   = !(R0_PROTECT && (rd_q == '0));
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rd_a_d  = '0;
                rd_b_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rd_a_d  = '0;
                rd_b_d  = '0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wr_c_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            wr_c_q    <= wr_c_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_a    = rd_a_q;
    assign bus.rd_b    = rd_b_q;
    assign bus.wr_c    = wr_c_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.carry   = carry_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: drives commands into reg_op_sequencer, models the
// register bank, and scores each completed operation against a reference model.
module tb_reg_op_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
        logic        zero;
        logic        carry;
        logic        wr;
        logic [31:0] wr_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_op_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_op_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_PROTECT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Register bank: registered reads, writes on the falling edge
    logic [31:0] bank [8];
    logic        preload;

    function automatic logic [31:0] init_val(int i);
        case (i)
            1: return 32'd7;
            2: return 32'd1;
            3: return 32'd14;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.rd_data1 <= bank[bus.rd_a];
        bus.rd_data2 <= bank[bus.rd_b];
    end

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) bank[i] <= init_val(i);
        end else if (bus.wr_en) begin
            bank[bus.wr_c] <= bus.wr_data;
        end
    end

    // Bench state
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          rise_count = 0;
    int          rise_cyc = 0;
    int          wr_total = 0;
    int          wr_cnt_op = 0;
    logic [31:0] wr_addr, wr_dat;
    logic        busy_prev = 1'b0;
    logic [31:0] mreg [8];
    exp_t        sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [32:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        case (op)
            3'b000: s = {1'b0, a} + {1'b0, b};
            3'b001: s = {(a < b), a - b};
            3'b010: s = {1'b0, a & b};
            3'b011: s = {1'b0, a | b};
            3'b100: s = {1'b0, a ^ b};
            3'b101: s = {1'b0, a << b[4:0]};
            3'b110: s = {1'b0, a >> b[4:0]};
            default: s = {1'b0, 31'd0, ($signed(a) < $signed(b))};
        endcase
        return s;
    endfunction

    // One clock: sample at the falling edge and score what the DUT produced
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.busy && !busy_prev) begin
            rise_count++;
            rise_cyc  = cyc;
            wr_cnt_op = 0;
            if (sb.size() > 0) begin
                check("rd_a", 32'(bus.rd_a), sb[0].rs);
                check("rd_b", 32'(bus.rd_b), sb[0].rt);
            end
        end
        if (bus.wr_en) begin
            wr_total++;
            wr_cnt_op++;
            wr_addr = 32'(bus.wr_c);
            wr_dat  = bus.wr_data;
        end
        if (bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("zero", 32'(bus.zero), 32'(e.zero));
                check("carry", 32'(bus.carry), 32'(e.carry));
                check("latency", 32'(cyc - rise_cyc), 32'd3);
                check("wr_pulses", 32'(wr_cnt_op), e.wr ? 32'd1 : 32'd0);
                if (e.wr) begin
                    check("wr_c", wr_addr, e.wr_c);
                    check("wr_data", wr_dat, e.res);
                end
            end
        end
        busy_prev = bus.busy;
    endtask

    // Drive a command and push the model's expectation
    task automatic issue(input logic [2:0] op, input int rs, input int rt, input int rd);
        exp_t        e;
        logic [32:0] r;
        r       = model_alu(op, mreg[rs], mreg[rt]);
        e.rs    = 32'(rs);
        e.rt    = 32'(rt);
        e.res   = r[31:0];
        e.carry = r[32];
        e.zero  = (r[31:0] == 32'd0);
        e.wr    = (rd != 0);
        e.wr_c  = 32'(rd);
        if (e.wr) mreg[rd] = r[31:0];
        sb.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = ADDR_W'(rs);
        bus.rt    = ADDR_W'(rt);
        bus.rd    = ADDR_W'(rd);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 20) begin
            tick();
            n++;
        end
        if (done_count < target) check("done_timeout", 32'(done_count), 32'(target));
    endtask

    task automatic run_op(input logic [2:0] op, input int rs, input int rt, input int rd);
        int d0;
        wait_idle();
        d0 = done_count;
        issue(op, rs, rt, rd);
        tick();
        bus.start = 1'b0;
        wait_done(d0 + 1);
    endtask

    initial begin
        int d0, r0, w0, first_rise;
        for (int i = 0; i < 8; i++) mreg[i] = init_val(i);
        preload   = 1'b1;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.rd    = '0;
        repeat (3) tick();
        preload = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_addrs", 32'({bus.rd_a, bus.rd_b, bus.wr_c}), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_status", 32'({bus.result != 0, bus.zero, bus.carry}), 32'd0);
        rst = 1'b0;
        tick();

        // Directed operations from the bank preload r1=7, r2=1, r3=14
        run_op(3'b000, 1, 3, 4);   // ADD -> 21
        run_op(3'b001, 2, 1, 5);   // SUB -> 0xFFFFFFFA, borrow
        run_op(3'b111, 5, 2, 6);   // SLT -> 1
        run_op(3'b110, 3, 2, 7);   // SRL -> 7
        w0 = wr_total;
        run_op(3'b100, 1, 1, 0);   // XOR into r0: suppressed write, zero=1
        check("r0_no_write", 32'(wr_total - w0), 32'd0);

        // start held high: second command only at the first IDLE edge
        wait_idle();
        d0 = done_count;
        r0 = rise_count;
        issue(3'b000, 1, 2, 6);
        tick();
        first_rise = rise_cyc;
        issue(3'b011, 3, 4, 7);
        for (int n = 0; n < 20 && done_count < d0 + 2; n++) begin
            tick();
            if (rise_count == r0 + 2) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("held_second_accept", 32'(rise_cyc - first_rise), 32'd5);
        repeat (8) tick();
        check("held_done_pulses", 32'(done_count - d0), 32'd2);
        check("held_accepts", 32'(rise_count - r0), 32'd2);

        // Back-to-back dependency through r1
        run_op(3'b000, 1, 1, 1);
        run_op(3'b000, 1, 2, 2);
        check("hazard_r1", bank[1], 32'd14);
        check("hazard_r2", bank[2], 32'd15);

        // Carry out of ADD, shifts and logic
        run_op(3'b000, 5, 3, 3);   // 0xFFFFFFFA + 14 -> 8, carry
        run_op(3'b101, 1, 2, 4);   // SLL 14 << 15
        run_op(3'b010, 5, 4, 6);
        run_op(3'b011, 1, 5, 7);

        // Reset while in EXEC aborts the operation
        wait_idle();
        d0 = done_count;
        w0 = wr_total;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.rs    = 3'd1;
        bus.rt    = 3'd2;
        bus.rd    = 3'd3;
        tick();                    // READ
        bus.start = 1'b0;
        tick();                    // EXEC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_rd_a", 32'(bus.rd_a), 32'd0);
        repeat (8) tick();
        check("abort_no_write", 32'(wr_total - w0), 32'd0);
        check("abort_no_done", 32'(done_count - d0), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("bank_r%0d", i), bank[i], mreg[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
